// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - fetch/loader arbiter for a single-port sync-read instruction memory
// Optional IMEM_ARB_PERF_EN adds grant and loader-starvation performance counters.
module imem_port_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
`ifdef IMEM_ARB_PERF_EN
    output logic [31:0]       perf_f_grants,
    output logic [31:0]       perf_ld_grants,
    output logic [31:0]       perf_starve_cycles,
`endif
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    input  logic              f_flush,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    output logic              f_err,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    input  logic              ld_lock,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [31:0]       ld_rdata,
    output logic              ld_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} owner_e;

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    owner_e     resp_owner_q, resp_owner_d;
    logic       resp_err_q, resp_err_d;
    logic       resp_we_q, resp_we_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       f_bad, ld_bad, f_win, ld_win;

    always_comb begin
        f_bad  = (f_addr[1:0] != 2'b00) || (f_addr[31:ADDR_W+2] != '0);
        ld_bad = (ld_addr[1:0] != 2'b00) || (ld_addr[31:ADDR_W+2] != '0);
        // Grants are gated by rst so every output drops the moment reset asserts.
        ld_win = rst && ld_req && (ld_lock || f_flush || !f_req || (wait_cnt_q == WAIT_MAX));
        f_win  = rst && !ld_win && f_req && !ld_lock && !f_flush;

        f_gnt     = f_win;
        ld_gnt    = ld_win;
        mem_en    = (ld_win && !ld_bad) || (f_win && !f_bad);
        mem_we    = ld_win && !ld_bad && ld_we;
        mem_addr  = ld_win ? ld_addr[ADDR_W+1:2] : (f_win ? f_addr[ADDR_W+1:2] : '0);
        mem_wdata = ld_win ? ld_wdata : 32'h0;

        resp_owner_d = ld_win ? OWN_LOAD : (f_win ? OWN_FETCH : OWN_NONE);
        resp_err_d   = ld_win ? ld_bad : (f_win && f_bad);
        resp_we_d    = ld_win && ld_we;

        wait_cnt_d = wait_cnt_q;
        if (!ld_req || ld_win)
            wait_cnt_d = 8'd0;
        else if (wait_cnt_q < WAIT_MAX)
            wait_cnt_d = wait_cnt_q + 8'd1;

        f_rvalid  = (resp_owner_q == OWN_FETCH) && !f_flush;
        f_err     = f_rvalid && resp_err_q;
        f_rdata   = (f_rvalid && !resp_err_q) ? mem_rdata : 32'h0;
        ld_rvalid = (resp_owner_q == OWN_LOAD);
        ld_err    = ld_rvalid && resp_err_q;
        ld_rdata  = (ld_rvalid && !resp_err_q && !resp_we_q) ? mem_rdata : 32'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_owner_q <= OWN_NONE;
            resp_err_q   <= 1'b0;
            resp_we_q    <= 1'b0;
            wait_cnt_q   <= 8'd0;
        end else begin
            resp_owner_q <= resp_owner_d;
            resp_err_q   <= resp_err_d;
            resp_we_q    <= resp_we_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] perf_f_grants_q, perf_f_grants_d;
    logic [31:0] perf_ld_grants_q, perf_ld_grants_d;
    logic [31:0] perf_starve_cycles_q, perf_starve_cycles_d;

    always_comb begin
        perf_f_grants_d      = perf_f_grants_q + {31'd0, f_win};
        perf_ld_grants_d     = perf_ld_grants_q + {31'd0, ld_win};
        perf_starve_cycles_d = perf_starve_cycles_q + {31'd0, (ld_req && !ld_win)};
        perf_f_grants        = perf_f_grants_q;
        perf_ld_grants       = perf_ld_grants_q;
        perf_starve_cycles   = perf_starve_cycles_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_f_grants_q      <= 32'd0;
            perf_ld_grants_q     <= 32'd0;
            perf_starve_cycles_q <= 32'd0;
        end else begin
            perf_f_grants_q      <= perf_f_grants_d;
            perf_ld_grants_q     <= perf_ld_grants_d;
            perf_starve_cycles_q <= perf_starve_cycles_d;
        end
    end
`endif
endmodule
